// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the Avalon LED PWM peripheral.
package led_pwm_pkg;

   localparam int LED_N = 8;

   // Word addresses of the register file
   localparam logic [3:0] ADDR_STATIC   = 4'd0;
   localparam logic [3:0] ADDR_PWM_EN   = 4'd1;
   localparam logic [3:0] ADDR_BLINK_EN = 4'd2;
   localparam logic [3:0] ADDR_PRESCALE = 4'd3;
   localparam logic [3:0] ADDR_DUTY0    = 4'd4;
   localparam logic [3:0] ADDR_DUTY7    = 4'd11;
   localparam logic [3:0] ADDR_STATUS   = 4'd12;

   // Slowest tick rate out of reset so the LEDs stay quiet until firmware sets a rate
   localparam logic [15:0] PRESCALE_RST = 16'hFFFF;

   typedef struct packed {
      logic        read;
      logic        write;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } avs_req_t;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit PWM counter and blink phase generator.
module pwm_timebase
   import led_pwm_pkg::*;
#(
   parameter int BLINK_BITS = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] prescale,
   input  logic        pre_clr,
   output logic        tick,
   output logic [7:0]  pwm_cnt,
   output logic        phase
);

   logic [15:0]           pre_cnt;
   logic [BLINK_BITS-1:0] blink_cnt;

   // Compare uses the registered prescale, so a write landing on a tick edge sees the old period
   assign tick = (pre_cnt == prescale);

   // Prescaler: restart on tick, or immediately when firmware rewrites the period
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                pre_cnt <= '0;
      else if (pre_clr || tick)    pre_cnt <= '0;
      else                         pre_cnt <= pre_cnt + 16'd1;
   end

   // PWM counter advances per tick; each wrap advances blink_cnt, whose wrap flips phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (pwm_cnt == 8'hFF) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) phase <= ~phase;
         end
      end
   end

endmodule

// File: rtl/avalon_led_pwm.sv
// Avalon-MM LED peripheral: register file, per-LED PWM compare, blink gate, output register.
module avalon_led_pwm
   import led_pwm_pkg::*;
#(
   parameter int BLINK_BITS     = 7,
   parameter bit LED_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   input  logic [3:0]       avs_byteenable,
   output logic [31:0]      avs_readdata,
   output logic [LED_N-1:0] led_signal
);

   avs_req_t req;
   assign req = '{read: avs_read, write: avs_write, addr: avs_address,
                  wdata: avs_writedata, be: avs_byteenable};

   logic [LED_N-1:0]            static_r, pwm_en_r, blink_en_r;
   logic [15:0]                 prescale_r;
   logic [LED_N-1:0][7:0]       duty_r;
   logic                        tick, phase;
   logic [7:0]                  pwm_cnt;
   logic [LED_N-1:0]            pwm_out, led_next;
   logic [31:0]                 rd_mux;
   logic                        duty_sel;
   logic [2:0]                  duty_idx;
   logic                        pre_clr;
   logic                        unused_bits;

   // Upper data lanes carry nothing for this block
   assign unused_bits = ^{req.wdata[31:16], req.be[3:2]};

   assign duty_sel = (req.addr >= ADDR_DUTY0) && (req.addr <= ADDR_DUTY7);
   assign duty_idx = req.addr[2:0] - 3'd4;   // 4..11 maps onto 0..7 modulo 8
   assign pre_clr  = req.write && (req.addr == ADDR_PRESCALE);

   pwm_timebase #(.BLINK_BITS(BLINK_BITS)) u_timebase (
      .clk      (clk),
      .reset_n  (reset_n),
      .prescale (prescale_r),
      .pre_clr  (pre_clr),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .phase    (phase)
   );

   // Register writes, honoured per byte lane (lane 1 only reaches PRESCALE)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         static_r   <= '0;
         pwm_en_r   <= '0;
         blink_en_r <= '0;
         prescale_r <= PRESCALE_RST;
         duty_r     <= '0;
      end else if (req.write) begin
         case (req.addr)
            ADDR_STATIC:   if (req.be[0]) static_r   <= req.wdata[7:0];
            ADDR_PWM_EN:   if (req.be[0]) pwm_en_r   <= req.wdata[7:0];
            ADDR_BLINK_EN: if (req.be[0]) blink_en_r <= req.wdata[7:0];
            ADDR_PRESCALE: begin
               if (req.be[0]) prescale_r[7:0]  <= req.wdata[7:0];
               if (req.be[1]) prescale_r[15:8] <= req.wdata[15:8];
            end
            default:       if (duty_sel && req.be[0]) duty_r[duty_idx] <= req.wdata[7:0];
         endcase
      end
   end

   // Read mux over pre-write state; unmapped bits and reserved words return 0
   always_comb begin
      rd_mux = '0;
      case (req.addr)
         ADDR_STATIC:   rd_mux[7:0]  = static_r;
         ADDR_PWM_EN:   rd_mux[7:0]  = pwm_en_r;
         ADDR_BLINK_EN: rd_mux[7:0]  = blink_en_r;
         ADDR_PRESCALE: rd_mux[15:0] = prescale_r;
         ADDR_STATUS:   rd_mux[8:0]  = {phase, pwm_cnt};
         default:       if (duty_sel) rd_mux[7:0] = duty_r[duty_idx];
      endcase
   end

   // Read data captured on the read edge and held until the next read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      avs_readdata <= '0;
      else if (req.read) avs_readdata <= rd_mux;
   end

   for (genvar n = 0; n < LED_N; n++) begin : g_led
      assign pwm_out[n]  = (pwm_cnt < duty_r[n]);
      assign led_next[n] = (pwm_en_r[n] ? pwm_out[n] : static_r[n]) & (~blink_en_r[n] | phase);
   end

   // Output register with optional polarity inversion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) led_signal <= {LED_N{LED_ACTIVE_LOW}};
      else          led_signal <= led_next ^ {LED_N{LED_ACTIVE_LOW}};
   end

endmodule

// File: tb/tb_avalon_led_pwm.sv
// Scoreboard bench for avalon_led_pwm against a tick-count reference model.
module tb_avalon_led_pwm;

   localparam int BB = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [3:0]  avs_byteenable = '0;
   logic [31:0] avs_readdata;
   logic [7:0]  led_signal;

   always #5 clk = ~clk;

   avalon_led_pwm #(.BLINK_BITS(BB), .LED_ACTIVE_LOW(1'b0)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_byteenable (avs_byteenable),
      .avs_readdata   (avs_readdata),
      .led_signal     (led_signal)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counters are derived from the number of ticks since reset.
   logic [7:0]  m_static, m_pwm_en, m_blink_en;
   logic [15:0] m_prescale;
   logic [7:0]  m_duty [8];
   int          m_pre;     // clocks since last tick or period rewrite
   int          m_ticks;   // ticks since reset
   logic [31:0] rd_q [$];
   logic [7:0]  led_q [$];

   task automatic m_reset();
      m_static = 0; m_pwm_en = 0; m_blink_en = 0;
      m_prescale = 16'hFFFF;
      for (int i = 0; i < 8; i++) m_duty[i] = 0;
      m_pre = 0; m_ticks = 0;
   endtask

   function automatic logic [7:0] m_cnt();
      return 8'(m_ticks % 256);
   endfunction

   function automatic logic m_phase();
      return ((m_ticks / (256 * (1 << BB))) % 2) != 0;
   endfunction

   function automatic logic [7:0] m_led();
      logic [7:0] v;
      logic b;
      for (int i = 0; i < 8; i++) begin
         b = m_pwm_en[i] ? (int'(m_cnt()) < int'(m_duty[i])) : m_static[i];
         v[i] = b & (!m_blink_en[i] || m_phase());
      end
      return v;
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return {24'd0, m_static};
      if (ai == 1) return {24'd0, m_pwm_en};
      if (ai == 2) return {24'd0, m_blink_en};
      if (ai == 3) return {16'd0, m_prescale};
      if (ai >= 4 && ai <= 11) return {24'd0, m_duty[ai-4]};
      if (ai == 12) return {23'd0, m_phase(), m_cnt()};
      return 32'd0;
   endfunction

   // Model step at each active edge: record expected outputs, then advance state
   initial begin
      logic tk;
      int   ai;
      m_reset();
      forever begin
         @(posedge clk);
         if (!reset_n) m_reset();
         else begin
            if (avs_read) rd_q.push_back(m_read(avs_address));
            led_q.push_back(m_led());
            tk = (m_pre == int'(m_prescale));
            if (tk) begin m_ticks++; m_pre = 0; end
            else m_pre++;
            if (avs_write) begin
               ai = int'(avs_address);
               if (avs_byteenable[0]) begin
                  if (ai == 0) m_static = avs_writedata[7:0];
                  if (ai == 1) m_pwm_en = avs_writedata[7:0];
                  if (ai == 2) m_blink_en = avs_writedata[7:0];
                  if (ai == 3) m_prescale[7:0] = avs_writedata[7:0];
                  if (ai >= 4 && ai <= 11) m_duty[ai-4] = avs_writedata[7:0];
               end
               if (avs_byteenable[1] && ai == 3) m_prescale[15:8] = avs_writedata[15:8];
               if (ai == 3) m_pre = 0;
            end
         end
      end
   end

   // Monitor: compares DUT outputs against queued expectations on the falling edge
   initial begin
      logic [31:0] e;
      logic [7:0]  l;
      forever begin
         @(negedge clk);
         if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check("readdata", avs_readdata, e);
         end
         if (led_q.size() > 0) begin
            l = led_q.pop_front();
            check("led", {24'd0, led_signal}, {24'd0, l});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus(input logic r, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be, output logic [31:0] rd);
      @(negedge clk);
      avs_read = r; avs_write = w; avs_address = a; avs_writedata = d; avs_byteenable = be;
      @(posedge clk);
      #1;
      avs_read = 1'b0; avs_write = 1'b0;
      rd = avs_readdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] dummy;
      bus(1'b0, 1'b1, a, d, be, dummy);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      bus(1'b1, 1'b0, a, 32'd0, 4'h0, v);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      rd_q.delete();
      led_q.delete();
      m_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic count_led0(input int cycles, output int hi);
      hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         hi += int'(led_signal[0]);
      end
   endtask

   initial begin
      logic [31:0] v, s1, s2;
      int hi, bad_hi, lo_nib;
      logic [3:0] a;
      logic [31:0] d;

      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      check("rst_led", {24'd0, led_signal}, 32'd0);
      check("rst_rdata", avs_readdata, 32'd0);
      rd(4'd3, v); check("rst_prescale", v, 32'h0000_FFFF);
      rd(4'd0, v); check("rst_static", v, 32'd0);

      // static write visible one clock after the write edge
      wr(4'd0, 32'hA5, 4'h1);
      @(posedge clk); #1;
      check("static_led", {24'd0, led_signal}, 32'hA5);
      rd(4'd0, v); check("static_rd", v, 32'hA5);

      // PWM duty over one full period
      wr(4'd0, 32'h0, 4'h1);
      wr(4'd3, 32'h0, 4'h3);
      wr(4'd4, 32'd64, 4'h1);
      wr(4'd1, 32'h01, 4'h1);
      repeat (4) @(posedge clk);
      count_led0(256, hi); check("duty64", hi, 64);
      wr(4'd4, 32'd0, 4'h1);
      repeat (4) @(posedge clk);
      count_led0(256, hi); check("duty0", hi, 0);
      wr(4'd4, 32'd255, 4'h1);
      repeat (4) @(posedge clk);
      count_led0(256, hi); check("duty255", hi, 255);

      // prescaler: one pwm step per 4 clocks, then immediate restart at period 0
      wr(4'd3, 32'd3, 4'h3);
      rd(4'd12, s1);
      repeat (3) @(posedge clk);
      rd(4'd12, s2);
      check("presc4_step", {24'd0, 8'(s2[7:0] - s1[7:0])}, 32'd1);
      repeat (2) @(posedge clk);
      wr(4'd3, 32'd0, 4'h3);
      rd(4'd12, s1);
      rd(4'd12, s2);
      check("presc0_next", {24'd0, 8'(s2[7:0] - s1[7:0])}, 32'd1);

      // blink: low nibble gated by phase, high nibble steady
      wr(4'd1, 32'h0, 4'h1);
      wr(4'd0, 32'hFF, 4'h1);
      wr(4'd2, 32'h0F, 4'h1);
      repeat (4) @(posedge clk);
      bad_hi = 0; lo_nib = 0;
      repeat (2048) begin
         @(negedge clk);
         if (led_signal[7:4] != 4'hF) bad_hi++;
         if (led_signal[3:0] == 4'h0) lo_nib++;
      end
      check("blink_hi", bad_hi, 0);
      check("blink_lo", lo_nib, 1024);

      // byte lanes, reserved space, read+write together
      do_reset();
      wr(4'd3, 32'h1234, 4'h1);
      rd(4'd3, v); check("be_lane0", v, 32'h0000_FF34);
      rd(4'd14, v); check("reserved", v, 32'd0);
      bus(1'b1, 1'b1, 4'd0, 32'h3C, 4'h1, v);
      check("rw_old", v, 32'd0);
      rd(4'd0, v); check("rw_new", v, 32'h3C);

      // randomized traffic with a reset in the middle
      wr(4'd3, 32'd1, 4'h3);
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            do_reset();
            wr(4'd3, 32'd0, 4'h3);
         end
         a = 4'($urandom_range(0, 15));
         d = $urandom;
         if (a == 4'd3) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
         case ($urandom_range(0, 3))
            0: @(posedge clk);
            1: bus(1'b1, 1'b0, a, d, 4'($urandom_range(1, 15)), v);
            2: bus(1'b0, 1'b1, a, d, 4'($urandom_range(1, 15)), v);
            default: bus(1'b1, 1'b1, a, d, 4'($urandom_range(1, 15)), v);
         endcase
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/avalon_led_pwm.md
# avalon_led_pwm

Avalon-MM slave LED peripheral for the picorv32 SoC on the CYC1000 board. It sits directly downstream of the CPU's Avalon interconnect and drives the board's 8 user LEDs. Each LED is either static or PWM-dimmed (8-bit duty), with an optional per-LED blink gate. Firmware programs it through a small word-addressed register file with fixed 1-cycle read latency.

## Interface
- `BLINK_BITS`, default 7: blink phase toggles every 2^BLINK_BITS PWM periods.
- `LED_ACTIVE_LOW`, default 0: 1 inverts `led_signal` at the output register.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `avs_address` in 4: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_byteenable` in 4: byte lanes; only lanes 0–1 are used.
- `avs_readdata` out 32: read data, valid 1 cycle after `avs_read`.
- `led_signal` out 8: LED drive, registered.

## Operation
- Register map (word addresses; unused bits read 0, writes ignored):
  - 0 `STATIC[7:0]`: per-LED value when PWM is disabled.
  - 1 `PWM_EN[7:0]`: bit n set means LED n uses duty n.
  - 2 `BLINK_EN[7:0]`: bit n set means LED n is ANDed with the blink phase.
  - 3 `PRESCALE[15:0]`: PWM tick every PRESCALE+1 clocks.
  - 4–11 `DUTY0..DUTY7[7:0]`.
  - 12 `STATUS`, read-only: [7:0] current `pwm_cnt`; [8] blink phase.
  - 13–15: reserved; read 0, writes ignored.
- Writes are honoured per byte lane; lane 1 matters only for `PRESCALE`. No waitrequest; every access completes.
- Prescaler:
  - `pre_cnt` 16-bit. When `pre_cnt == PRESCALE`, it returns to 0 and `tick` pulses; otherwise it increments.
  - `PRESCALE = 0` gives a tick every clock.
- PWM:
  - `pwm_cnt` 8-bit, increments on `tick`, wraps 255 to 0.
  - `pwm_out[n] = (pwm_cnt < DUTY[n])`.
  - `DUTY = 0` is always off; `DUTY = 255` is on 255 of 256 counts.
- Blink:
  - `blink_cnt` BLINK_BITS wide, increments on each `pwm_cnt` wrap (tick while at 255).
  - Phase toggles when `blink_cnt` wraps to 0.
- Output: `base[n] = PWM_EN[n] ? pwm_out[n] : STATIC[n]`; `led_next[n] = base[n] & (~BLINK_EN[n] | phase)`. Output is then XORed with `LED_ACTIVE_LOW`.
- A write to `PRESCALE` clears `pre_cnt` in the same edge. This prevents a long wait when shrinking the period below the current count.
- Counters `pwm_cnt` and `blink_cnt` are never cleared by register writes.

## Timing
- Reset values (asynchronous):
  - All registers 0. `PRESCALE` resets to 0xFFFF.
  - All counters 0; phase 0.
  - `avs_readdata` 0.
  - `led_signal` = 8'h00, or 8'hFF if `LED_ACTIVE_LOW`.
- Read: address sampled on the `avs_read` edge; `avs_readdata` valid on the next edge and held until the next read.
- Write: register updated on the edge with `avs_write`. The effect reaches `led_signal` one clock later (registered output).
- Read and write asserted together: the write takes effect and the read returns the pre-write value.
- A write coinciding with `tick` uses the old `DUTY`/`PRESCALE` for that tick's compare.
- Deasserting `reset_n` mid-period restarts all counters from 0. There is no partial state.

## Structure
- Shared package `led_pwm_pkg`:
  - Register address localparams `ADDR_STATIC` .. `ADDR_STATUS`.
  - `PRESCALE` reset constant.
  - `LED_N = 8`.
- One sub-module, `pwm_timebase`: owns the prescaler, `pwm_cnt`, `blink_cnt` and phase. Outputs are `tick`, `pwm_cnt` and `phase`.
- Register file, per-LED compare and output register live in the top module.

## Test plan
- Reset: hold `reset_n` low, release → `led_signal = 0x00`, read addr 3 = 0x0000FFFF, addr 0 = 0.
- Static write: write addr 0 = 0xA5 → `led_signal = 0xA5` two edges after the write strobe; read addr 0 returns 0xA5.
- PWM duty: `PRESCALE = 0`, `DUTY0 = 64`, `PWM_EN = 0x01` → `led_signal[0]` high exactly 64 of every 256 clocks; `DUTY0 = 0` gives always low.
- Prescaler change: `PRESCALE = 3` → `pwm_cnt` in STATUS advances every 4 clocks. Rewrite to 0 mid-count → next tick on the following clock.
- Blink: `BLINK_BITS = 2`, `PRESCALE = 0`, `STATIC = 0xFF`, `BLINK_EN = 0x0F` → low nibble toggles every 4×256 clocks; high nibble stays 1.
- Byte enables and reserved space: write 0x1234 to addr 3 with byteenable 0x1 → reads 0xFF34. Read addr 14 → 0.
